// File: rtl/coin_return_dispenser_if.sv
// Refund request/amount from the vending controller and coin-motor drive/status back to it.
interface coin_return_dispenser_if;
  logic        refund_req;
  logic [11:0] amount;
  logic        busy;
  logic        dollar_out;
  logic        quarter_out;
  logic        done;
  logic [4:0]  remainder;

  modport master (
    output refund_req, amount,
    input  busy, dollar_out, quarter_out, done, remainder
  );

  modport slave (
    input  refund_req, amount,
    output busy, dollar_out, quarter_out, done, remainder
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// Turns a latched cents balance into timed dollar then quarter hopper pulses, reports leftover cents.
// Busy = coins*(1+PULSE+GAP)+2 cycles; requests arriving while busy are dropped, never queued.
module coin_return_dispenser #(
  parameter int PULSE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 25_000_000
) (
  input logic                   clk,
  input logic                   reset,
  coin_return_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SELECT, D_ON, D_GAP, Q_ON, Q_GAP, DONE
  } state_t;

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW      = ($clog2(MAX_CYC) > 26) ? $clog2(MAX_CYC) : 26;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [11:0]   bal, bal_nxt;
  logic [4:0]    rem_q, rem_nxt;
  logic          req_prev;
  logic          req_edge;
  logic          busy_q, dollar_q, quarter_q, done_q;

  assign req_edge = bus.refund_req & ~req_prev;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    bal_nxt   = bal;
    rem_nxt   = rem_q;
    case (state)
      IDLE: begin
        if (req_edge) begin
          bal_nxt   = bus.amount;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (bal >= 12'd100) begin
          state_nxt = D_ON;
          timer_nxt = PULSE_LOAD;
        end else if (bal >= 12'd25) begin
          state_nxt = Q_ON;
          timer_nxt = PULSE_LOAD;
        end else begin
          state_nxt = DONE;
        end
      end
      D_ON: begin
        if (timer == '0) begin
          state_nxt = D_GAP;
          timer_nxt = GAP_LOAD;
          bal_nxt   = bal - 12'd100;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      Q_ON: begin
        if (timer == '0) begin
          state_nxt = Q_GAP;
          timer_nxt = GAP_LOAD;
          bal_nxt   = bal - 12'd25;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      D_GAP, Q_GAP: begin
        if (timer == '0) begin
          state_nxt = SELECT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Capture the leftover as DONE is entered so it is already valid alongside the done strobe.
    if (state_nxt == DONE) begin
      rem_nxt = bal_nxt[4:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      bal       <= '0;
      rem_q     <= '0;
      req_prev  <= 1'b0;
      busy_q    <= 1'b0;
      dollar_q  <= 1'b0;
      quarter_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bal       <= bal_nxt;
      rem_q     <= rem_nxt;
      req_prev  <= bus.refund_req;
      // Outputs are flopped from the next state so they toggle cleanly with the state register.
      busy_q    <= (state_nxt != IDLE);
      dollar_q  <= (state_nxt == D_ON);
      quarter_q <= (state_nxt == Q_ON);
      done_q    <= (state_nxt == DONE);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.dollar_out  = dollar_q;
  assign bus.quarter_out = quarter_q;
  assign bus.done        = done_q;
  assign bus.remainder   = rem_q;

endmodule
